// File: rtl/qkv_writeback_ctrl_if.sv
// Result-stream handshake plus BRAM port-A write bus for qkv_writeback_ctrl.
// master = stream producer / BRAM side, slave = the writeback controller.
interface qkv_writeback_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 256
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  ena;
    logic                  wea;
    logic [ADDR_WIDTH-1:0] addra;
    logic [DATA_WIDTH-1:0] dina;

    modport master (output s_valid, s_data, input s_ready, ena, wea, addra, dina);
    modport slave  (input s_valid, s_data, output s_ready, ena, wea, addra, dina);
endinterface

// File: rtl/qkv_writeback_ctrl.sv
// Streams result beats into the Q/K/V regions of a BRAM, one write per accepted beat.
// Optional macro QKV_WB_ERR_EN adds a sticky err output (invalid select or offset wrap).
module qkv_writeback_ctrl #(
    parameter int unsigned ADDR_WIDTH       = 16,
    parameter int unsigned ORIGINAL_COLUMNS = 768,
    parameter int unsigned ORIGINAL_ROWS    = 512,
    parameter int unsigned NUM_BITS         = 8,
    parameter int unsigned DATA_WIDTH       = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_store,
    input  logic                 reset_addr_counter,
    input  logic [2:0]           Buffer_Select,
    input  logic                 Tiles_Control,
    qkv_writeback_ctrl_if.slave  bus,
    output logic                 busy,
    output logic                 store_done
`ifdef QKV_WB_ERR_EN
    ,
    output logic                 err
`endif
);
    localparam int unsigned ROW_WORDS  = ORIGINAL_COLUMNS * NUM_BITS / DATA_WIDTH;
    localparam int unsigned BUF_WORDS  = ORIGINAL_ROWS * ROW_WORDS;
    localparam int unsigned TILE_WORDS = 32 * ROW_WORDS;
    localparam int unsigned OFF_W      = (BUF_WORDS > 1) ? $clog2(BUF_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, STORE, DONE} state_t;

    state_t           state, state_n;
    logic [1:0]       sel_q;
    logic             tiles_q;
    logic [OFF_W-1:0] beat_cnt;
    logic [OFF_W-1:0] offs [3];

    logic                  sel_valid;
    logic                  start_ok;
    logic                  accept;
    logic                  last_beat;
    logic                  off_wrap;
    logic [1:0]            sel_idx;
    logic [OFF_W-1:0]      cur_off;
    logic [OFF_W-1:0]      last_cnt;
    logic [ADDR_WIDTH-1:0] base;

    // Decode of the request and current burst context
    always_comb begin
        sel_valid = (Buffer_Select == 3'b011) || (Buffer_Select == 3'b100) ||
                    (Buffer_Select == 3'b101);
        start_ok  = start_store && sel_valid;
        case (Buffer_Select)
            3'b011:  sel_idx = 2'd0;
            3'b100:  sel_idx = 2'd1;
            default: sel_idx = 2'd2;
        endcase
        case (sel_q)
            2'd0:    base = '0;
            2'd1:    base = ADDR_WIDTH'(BUF_WORDS);
            default: base = ADDR_WIDTH'(2 * BUF_WORDS);
        endcase
        cur_off   = offs[sel_q];
        off_wrap  = (cur_off == OFF_W'(BUF_WORDS - 1));
        last_cnt  = tiles_q ? OFF_W'(TILE_WORDS - 1) : OFF_W'(BUF_WORDS - 1);
        accept    = bus.s_valid && bus.s_ready;
        last_beat = accept && (beat_cnt == last_cnt);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start_ok) state_n = STORE;
            STORE:   if (last_beat) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Registered outputs, burst context and per-buffer offsets
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q       <= '0;
            tiles_q     <= 1'b0;
            beat_cnt    <= '0;
            for (int i = 0; i < 3; i++) offs[i] <= '0;
            busy        <= 1'b0;
            store_done  <= 1'b0;
            bus.s_ready <= 1'b0;
            bus.ena     <= 1'b0;
            bus.wea     <= 1'b0;
            bus.addra   <= '0;
            bus.dina    <= '0;
        end else begin
            busy        <= (state_n != IDLE);
            bus.s_ready <= (state_n == STORE);
            store_done  <= (state_n == DONE);
            bus.ena     <= accept;
            bus.wea     <= accept;
            if (state == IDLE && start_ok) begin
                sel_q    <= sel_idx;
                tiles_q  <= Tiles_Control;
                beat_cnt <= '0;
            end
            if (state == IDLE && reset_addr_counter) begin
                for (int i = 0; i < 3; i++) offs[i] <= '0;
            end
            // Accepts only occur in STORE, so they never race the IDLE clear
            if (accept) begin
                bus.addra     <= base + ADDR_WIDTH'(cur_off);
                bus.dina      <= bus.s_data;
                offs[sel_q]   <= off_wrap ? '0 : cur_off + OFF_W'(1);
                beat_cnt      <= beat_cnt + OFF_W'(1);
            end
        end
    end

`ifdef QKV_WB_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) err <= 1'b0;
        else if ((state == IDLE && start_store && !sel_valid) || (accept && off_wrap))
            err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_qkv_writeback_ctrl.sv
// Directed bench for qkv_writeback_ctrl: Q/K/V bursts, gaps, wrap, invalid select,
// mid-burst reset and reset_addr_counter handling, with hand-derived addresses.
module tb_qkv_writeback_ctrl;
    localparam int unsigned ADDR_WIDTH = 16;
    localparam int unsigned DATA_WIDTH = 256;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_store;
    logic       reset_addr_counter;
    logic [2:0] Buffer_Select;
    logic       Tiles_Control;
    logic       busy;
    logic       store_done;
`ifdef QKV_WB_ERR_EN
    logic       err;
`endif

    int vectors = 0;
    int fails   = 0;

    qkv_writeback_ctrl_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

    qkv_writeback_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .start_store        (start_store),
        .reset_addr_counter (reset_addr_counter),
        .Buffer_Select      (Buffer_Select),
        .Tiles_Control      (Tiles_Control),
        .bus                (bus),
        .busy               (busy),
        .store_done         (store_done)
`ifdef QKV_WB_ERR_EN
        ,
        .err                (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DATA_WIDTH-1:0] got,
                         input logic [DATA_WIDTH-1:0] exp);
        vectors++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic logic [DATA_WIDTH-1:0] beat_data(input int tag, input int n);
        logic [31:0] w;
        w = 32'(tag * 65536 + n);
        return {(DATA_WIDTH/32){w}};
    endfunction

    // Starts a burst and drives/scores it cycle by cycle; caller is at a negedge.
    task automatic run_burst(input logic [2:0] sel, input logic tiles, input bit gap,
                             input int start_addr, input int abort_after,
                             input bit rac_start, input bit rac_mid, input int tag);
        int beats;
        int accepted = 0;
        int writes   = 0;
        int cyc      = 0;
        bit pend     = 1'b0;
        bit done     = 1'b0;
        bit valid;
        logic [ADDR_WIDTH-1:0] exp_addr = '0;
        logic [DATA_WIDTH-1:0] exp_data = '0;
        beats = tiles ? 768 : 12288;

        start_store        = 1'b1;
        Buffer_Select      = sel;
        Tiles_Control      = tiles;
        reset_addr_counter = rac_start;
        @(negedge clk);
        start_store        = 1'b0;
        reset_addr_counter = 1'b0;
        check("busy_at_start", busy, 1);
        check("s_ready_at_start", bus.s_ready, 1);

        while (cyc < 2 * beats + 20) begin
            check("ena", bus.ena, pend);
            if (pend) begin
                writes++;
                check("wea", bus.wea, 1);
                check("addra", bus.addra, exp_addr);
                check("dina", bus.dina, exp_data);
            end
            check("store_done", store_done, pend && (writes == beats));
            if (pend && writes == beats) begin
                done = 1'b1;
                break;
            end
            if (abort_after > 0 && accepted == abort_after) begin
                // Beat offered on the reset edge must never be written
                rst         = 1'b1;
                bus.s_valid = 1'b1;
                bus.s_data  = beat_data(tag, accepted);
                @(negedge clk);
                rst         = 1'b0;
                bus.s_valid = 1'b0;
                check("abort_ena", bus.ena, 0);
                check("abort_store_done", store_done, 0);
                check("abort_busy", busy, 0);
                check("abort_s_ready", bus.s_ready, 0);
                return;
            end
            reset_addr_counter = rac_mid && (cyc == 5);
            valid       = (accepted < beats) && (!gap || (cyc % 2 == 0));
            bus.s_valid = valid;
            bus.s_data  = beat_data(tag, accepted);
            if (valid && bus.s_ready) begin
                pend     = 1'b1;
                exp_addr = ADDR_WIDTH'(start_addr + accepted);
                exp_data = beat_data(tag, accepted);
                accepted++;
            end else begin
                pend = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        if (!done) check("burst_timeout", 0, 1);
        bus.s_valid        = 1'b0;
        reset_addr_counter = 1'b0;
        @(negedge clk);
        check("post_busy", busy, 0);
        check("post_s_ready", bus.s_ready, 0);
        check("post_ena", bus.ena, 0);
        check("post_store_done", store_done, 0);
    endtask

    initial begin
        rst                = 1'b1;
        start_store        = 1'b0;
        reset_addr_counter = 1'b0;
        Buffer_Select      = 3'b000;
        Tiles_Control      = 1'b0;
        bus.s_valid        = 1'b0;
        bus.s_data         = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ena", bus.ena, 0);
        check("rst_wea", bus.wea, 0);
        check("rst_addra", bus.addra, 0);
        check("rst_dina", bus.dina, 0);
        check("rst_s_ready", bus.s_ready, 0);
        check("rst_store_done", store_done, 0);
`ifdef QKV_WB_ERR_EN
        check("rst_err", err, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Invalid select is ignored
        start_store   = 1'b1;
        Buffer_Select = 3'b111;
        @(negedge clk);
        start_store = 1'b0;
        check("inv_busy", busy, 0);
        check("inv_s_ready", bus.s_ready, 0);
        @(negedge clk);
        check("inv_busy2", busy, 0);
        check("inv_ena", bus.ena, 0);
`ifdef QKV_WB_ERR_EN
        check("inv_err", err, 1);
`endif

        // K tile bursts continue from the previous end
        run_burst(3'b100, 1'b1, 1'b0, 12288, 0, 1'b0, 1'b0, 1);
        run_burst(3'b100, 1'b1, 1'b0, 13056, 0, 1'b0, 1'b0, 2);
        // Full Q buffer with gaps, then a tile showing the offset wrapped to 0
        run_burst(3'b011, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 3);
        run_burst(3'b011, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 4);
        // reset_addr_counter during STORE is ignored; with start it clears first
        run_burst(3'b100, 1'b1, 1'b0, 13824, 0, 1'b0, 1'b1, 5);
        run_burst(3'b100, 1'b1, 1'b0, 12288, 0, 1'b1, 1'b0, 6);
        // V burst aborted by rst after 100 beats, then restarted at the V base
        run_burst(3'b101, 1'b1, 1'b0, 24576, 100, 1'b0, 1'b0, 7);
        @(negedge clk);
        check("post_abort_ena", bus.ena, 0);
        check("post_abort_store_done", store_done, 0);
        run_burst(3'b101, 1'b1, 1'b0, 24576, 0, 1'b0, 1'b0, 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule

// File: doc/qkv_writeback_ctrl.md
QKV_WRITEBACK_CTRL -- requirements
Module: qkv_writeback_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, BRAM port-A address width.
REQ-002 SHALL have parameter ORIGINAL_COLUMNS, default 768, matrix columns.
REQ-003 SHALL have parameter ORIGINAL_ROWS, default 512, matrix rows.
REQ-004 SHALL have parameter NUM_BITS, default 8, element width.
REQ-005 SHALL have parameter DATA_WIDTH, default 256, BRAM word width.
REQ-006 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port start_store, input, 1, one-cycle burst request.
REQ-009 SHALL have port reset_addr_counter, input, 1, clears all buffer offset counters.
REQ-010 SHALL have port Buffer_Select, input, 3, target buffer: 3'b011 Q, 3'b100 K, 3'b101 V.
REQ-011 SHALL have port Tiles_Control, input, 1, burst size: 1 = 32 rows, 0 = ORIGINAL_ROWS rows.
REQ-012 SHALL have ports s_valid (input, 1), s_ready (output, 1) and s_data (input, DATA_WIDTH), the result-stream handshake.
REQ-013 SHALL have ports ena (output, 1), wea (output, 1), addra (output, ADDR_WIDTH) and dina (output, DATA_WIDTH), the BRAM write port.
REQ-014 SHALL have ports busy (output, 1), high outside IDLE, and store_done (output, 1), a one-cycle completion pulse.

Function
REQ-015 SHALL define ROW_WORDS = ORIGINAL_COLUMNS*NUM_BITS/DATA_WIDTH (default 24) and BUF_WORDS = ORIGINAL_ROWS*ROW_WORDS (default 12288).
REQ-016 SHALL set burst length to 32*ROW_WORDS (768) when Tiles_Control=1, else BUF_WORDS (12288).
REQ-017 SHALL use buffer base addresses Q = 0, K = BUF_WORDS, V = 2*BUF_WORDS.
REQ-018 SHALL keep three independent offset counters (Q, K, V), so a later burst to the same buffer continues from the previous end.
REQ-019 SHALL wrap an offset counter from BUF_WORDS-1 to 0.
REQ-020 SHALL implement the states IDLE, STORE and DONE.
REQ-021 SHALL, in IDLE, on start_store=1 with a valid Buffer_Select, latch Buffer_Select and Tiles_Control, clear the beat counter and enter STORE.
REQ-022 SHALL ignore start_store in IDLE when Buffer_Select is invalid (not 011/100/101), remaining in IDLE.
REQ-023 SHALL ignore start_store outside IDLE.
REQ-024 SHALL drive s_ready=1 only in STORE.
REQ-025 SHALL treat a beat as accepted when s_valid && s_ready.
REQ-026 SHALL, one cycle after each accepted beat, drive ena=wea=1, addra = base + offset and dina = s_data for exactly one cycle, then increment that buffer's offset; write latency is 1 cycle.
REQ-027 SHALL drive ena=wea=0 in every cycle without a write; addra and dina hold their last values.
REQ-028 SHALL, when the burst's last beat is accepted, deassert s_ready in the next cycle and enter DONE.
REQ-029 SHALL, in DONE, pulse store_done=1 for one cycle coincident with the last BRAM write, then return to IDLE.
REQ-030 SHALL let a gap in s_valid insert no write and leave counters unchanged.
REQ-031 SHALL honour reset_addr_counter only in IDLE, clearing all three offsets to 0, and ignore it otherwise.
REQ-032 SHALL, when reset_addr_counter and start_store are both high in IDLE, clear the offsets and start the burst at offset 0.

Reset
REQ-033 SHALL, on rst=1 at a clock edge, enter IDLE and zero the offset counters, beat counter, ena, wea, addra, dina, s_ready, busy and store_done.
REQ-034 SHALL abort any in-flight burst on rst asserted mid-burst; the pending write is dropped and no store_done is issued.

Configuration
REQ-035 SHALL, with QKV_WB_ERR_EN defined, add output err (1 bit), set sticky on an ignored invalid-select start or on any offset wrap, cleared only by rst.
REQ-036 SHALL, with QKV_WB_ERR_EN undefined, have no err port and no associated logic; all other behaviour is identical.

Verification
REQ-037 SHALL check: reset then start_store with Buffer_Select=100, Tiles_Control=1 and 768 continuous beats -> writes to addra 12288..13055, dina equal to the beat data, store_done once at the last write.
REQ-038 SHALL check: the same K burst again without reset_addr_counter -> addra 13056..13823.
REQ-039 SHALL check: Buffer_Select=011, Tiles_Control=0 and s_valid toggling every other cycle -> 12288 writes to addra 0..12287, no write in gap cycles, Q offset wraps to 0.
REQ-040 SHALL check: Buffer_Select=111 with start_store -> busy stays 0, no writes; err=1 with QKV_WB_ERR_EN defined.
REQ-041 SHALL check: rst asserted after 100 beats of a V burst -> ena=0 next cycle, no store_done; a new V burst starts at addra 24576.
REQ-042 SHALL check: reset_addr_counter during STORE is ignored; with start_store in the same IDLE cycle, the burst begins at offset 0.
